// File: rtl/mic_pkg.sv
// Shared types and default sizing for the microphone frame sequencer.
// Single clock domain; holds no logic, so it adds no latency and applies no backpressure.
package mic_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_DECIM      = 9;
    localparam int DEF_FRAME_LEN  = 512;
    localparam int DEF_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } seq_state_t;

    typedef struct packed {
        logic                  tlast;
        logic [DEF_DATA_W-1:0] data;
    } frame_word_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO of frame words: a write is visible at the head one edge later.
// wr_vld is ignored while full unless the head is popped in the same cycle.
module sample_fifo
    import mic_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wr_vld,
    input  frame_word_t wr_dat,
    output logic        full,
    input  logic        rd_rdy,
    output logic        rd_vld,
    output frame_word_t rd_dat
);

    localparam int AW = $clog2(DEPTH);

    frame_word_t   mem_q [DEPTH];
    frame_word_t   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          empty, do_wr, do_rd;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign do_rd  = rd_rdy && !empty;
    assign do_wr  = wr_vld && (!full || do_rd);
    assign rd_vld = !empty;
    assign rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mic_frame_sequencer.sv
// Decimates the FIR stream into FRAME_LEN-sample AXI-Stream frames; kept sample visible one edge later.
// Input cannot stall: kept samples meeting a full FIFO are dropped (counted under MIC_FRAME_DROP_COUNT_EN).
module mic_frame_sequencer
    import mic_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DECIM      = DEF_DECIM,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              en,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic [15:0]       drop_count
);

    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int IW  = $clog2(FRAME_LEN);

    seq_state_t     state_q, state_d;
    logic [DCW-1:0] dec_cnt_q, dec_cnt_d;
    logic [IW-1:0]  wr_idx_q, wr_idx_d;
    logic           fifo_full, fifo_vld, pop, kept, wr_ok;
    frame_word_t    wr_word, rd_word;

    assign pop           = fifo_vld && m_axis_tready;
    assign kept          = (state_q != IDLE) && s_axis_tvalid && (dec_cnt_q == '0);
    assign wr_ok         = kept && (!fifo_full || pop);
    assign wr_word.tlast = (wr_idx_q == IW'(FRAME_LEN - 1));
    assign wr_word.data  = DEF_DATA_W'(s_axis_tdata);

    always_comb begin
        state_d   = state_q;
        dec_cnt_d = dec_cnt_q;
        wr_idx_d  = wr_idx_q;
        if (state_q == IDLE) begin
            dec_cnt_d = '0;
            wr_idx_d  = '0;
            if (en) begin
                state_d = RUN;
            end
        end else begin
            if (s_axis_tvalid) begin
                dec_cnt_d = (dec_cnt_q == DCW'(DECIM - 1)) ? '0 : dec_cnt_q + DCW'(1);
            end
            if (wr_ok) begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
            // Judge frame position after this cycle's write so a just-completed frame is not reopened.
            if (state_q == RUN && !en) begin
                state_d = (wr_idx_d == '0) ? IDLE : FINISH;
            end
            if (state_q == FINISH && wr_ok && wr_word.tlast) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            dec_cnt_q <= '0;
            wr_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            dec_cnt_q <= dec_cnt_d;
            wr_idx_q  <= wr_idx_d;
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .wr_vld (wr_ok),
        .wr_dat (wr_word),
        .full   (fifo_full),
        .rd_rdy (m_axis_tready),
        .rd_vld (fifo_vld),
        .rd_dat (rd_word)
    );

    assign m_axis_tvalid = fifo_vld;
    assign m_axis_tdata  = DATA_W'(rd_word.data);
    assign m_axis_tlast  = rd_word.tlast;
    assign busy          = (state_q != IDLE) || fifo_vld;

`ifdef MIC_FRAME_DROP_COUNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (kept && !wr_ok && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule
